// File: rtl/if_prefetch.sv
// Instruction prefetcher: issues sequential fetches into a small {pc, instr} queue with redirect flush.
// Optional performance counters (fetch_cnt, flush_cnt) are enabled by defining IF_PERF_CNT_EN.
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] im_add,
    input  logic [31:0] im_data,
    output logic        im_en,
    output logic        im_rd_wr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      add_q;
    logic [31:0]      ret_pc_p1;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic issue;
    logic push;
    logic pop;
    logic unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    // A slot is reserved for every outstanding read, so a return can always be stored.
    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (!rst && !redirect) begin
            issue = (count + CNT_W'(inflight)) < CNT_W'(DEPTH);
            push  = inflight;
            pop   = (count != '0) && id_ready;
        end
    end

    assign im_en    = issue;
    assign im_rd_wr = 1'b0;
    assign im_add   = rst ? RESET_PC : (issue ? fetch_pc : add_q);
    assign if_valid = !rst && (count != '0);
    assign if_instr = instr_mem[rd_ptr];
    assign if_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            add_q    <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                add_q    <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Return stage: the address of the outstanding read travels with it into the queue.
    always_ff @(posedge clk) begin
        if (issue) ret_pc_p1 <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr]    <= ret_pc_p1;
            instr_mem[wr_ptr] <= im_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push)     fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench for if_prefetch against a queue-based reference of the fetch stream.
module tb_if_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] im_add;
    logic [31:0] im_data;
    logic        im_en;
    logic        im_rd_wr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .im_add(im_add), .im_data(im_data), .im_en(im_en),
        .im_rd_wr(im_rd_wr), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: pending instructions as queues, one outstanding read, sequential pc.
    logic [31:0] key = 32'h0;
    logic [31:0] m_fetch = RPC;
    logic [31:0] m_add = RPC;
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;
    logic [31:0] m_infl_word = '0;
    logic [31:0] q_pc[$];
    logic [31:0] q_word[$];
    logic [31:0] m_fetch_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit          exp_en;
        bit          mem_en;
        logic [31:0] mem_add;
        @(negedge clk);
        exp_en = !rst && !redirect && ((q_pc.size() + int'(m_infl)) < DEPTH);
        if (rst) begin
            check("rst_im_en", 32'(im_en), 32'd0);
            check("rst_im_add", im_add, RPC);
            check("rst_if_valid", 32'(if_valid), 32'd0);
        end else begin
            check("im_en", 32'(im_en), 32'(exp_en));
            check("im_add", im_add, exp_en ? m_fetch : m_add);
            check("if_valid", 32'(if_valid), 32'(q_pc.size() != 0));
            if (q_pc.size() != 0) begin
                check("if_pc", if_pc, q_pc[0]);
                check("if_instr", if_instr, q_word[0]);
            end
        end
        check("im_rd_wr", 32'(im_rd_wr), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, m_fetch_cnt);
        check("flush_cnt", flush_cnt, m_flush_cnt);
`endif
        mem_en  = im_en;
        mem_add = im_add;

        if (rst) begin
            q_pc.delete(); q_word.delete();
            m_fetch = RPC; m_add = RPC; m_infl = 1'b0;
            m_fetch_cnt = '0; m_flush_cnt = '0;
        end else if (redirect) begin
            q_pc.delete(); q_word.delete();
            m_infl  = 1'b0;
            m_fetch = {redirect_pc[31:2], 2'b00};
            m_flush_cnt++;
        end else begin
            if (q_pc.size() != 0 && id_ready) begin
                void'(q_pc.pop_front());
                void'(q_word.pop_front());
            end
            if (m_infl) begin
                q_pc.push_back(m_infl_pc);
                q_word.push_back(m_infl_word);
                m_fetch_cnt++;
            end
            m_infl = exp_en;
            if (exp_en) begin
                m_infl_pc   = m_fetch;
                m_infl_word = mem_word(m_fetch);
                m_add       = m_fetch;
                m_fetch     = m_fetch + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        im_data = mem_en ? mem_word(mem_add) : $urandom();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0; im_data = '0;
        run(3);
        rst = 1'b0; id_ready = 1'b1;
        run(12);
        // Decode stall: queue fills, fetch stops, then drains in order.
        id_ready = 1'b0;
        run(10);
        id_ready = 1'b1;
        run(8);
        // Redirect with a read outstanding; misaligned target.
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        run(1);
        redirect = 1'b0;
        run(6);
        // Redirect together with a pop while the queue is partly full.
        id_ready = 1'b0;
        run(3);
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        run(1);
        redirect = 1'b0;
        run(5);
        // Address wrap at the top of memory.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        run(1);
        redirect = 1'b0;
        run(6);
        // Random traffic with distinct instruction words.
        key = 32'h5A5A_C3C3;
        for (int i = 0; i < 400; i++) begin
            id_ready    = ($urandom_range(9) < 7);
            redirect    = ($urandom_range(19) == 0);
            redirect_pc = $urandom();
            rst         = ($urandom_range(99) == 0);
            run(1);
        end
        // Reset with a full queue.
        rst = 1'b0; redirect = 1'b0; id_ready = 1'b0;
        run(8);
        rst = 1'b1;
        run(1);
        rst = 1'b0; id_ready = 1'b1;
        run(6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries, power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port im_add, output, 32 bits: instruction memory byte address.
REQ-006 SHALL have port im_data, input, 32 bits: instruction memory read data, valid exactly one cycle after im_en.
REQ-007 SHALL have port im_en, output, 1 bit: memory request strobe.
REQ-008 SHALL have port im_rd_wr, output, 1 bit: 0 = read; always 0 in this block.
REQ-009 SHALL have port redirect, input, 1 bit: flush and restart fetch from redirect_pc.
REQ-010 SHALL have port redirect_pc, input, 32 bits: new fetch address; bits [1:0] ignored and treated as 0.
REQ-011 SHALL have port if_valid, output, 1 bit: queue head holds a valid instruction.
REQ-012 SHALL have port if_instr, output, 32 bits: instruction at queue head.
REQ-013 SHALL have port if_pc, output, 32 bits: byte address of if_instr.
REQ-014 SHALL have port id_ready, input, 1 bit: decode accepts the head; a pop occurs when if_valid and id_ready are both high.

Function
REQ-015 SHALL hold fetch_pc, a DEPTH-entry FIFO of {pc, instr}, a count, and a 1-bit inflight flag.
REQ-016 SHALL assert im_en with im_add = fetch_pc in a cycle only when count + inflight < DEPTH and redirect = 0.
REQ-017 On each issue, SHALL set inflight for the next cycle and advance fetch_pc by 4, wrapping 32'hFFFF_FFFC to 0.
REQ-018 SHALL write im_data and its pc into the FIFO at the end of the cycle after issue, unless a redirect occurred in the issue cycle or the return cycle.
REQ-019 Request latency SHALL be: issue in cycle C, data on im_data in C+1, if_valid high with that instruction in C+2; there is no bypass.
REQ-020 With id_ready held high, SHALL sustain one instruction per cycle.
REQ-021 SHALL permit push and pop in the same cycle; count is unchanged and the FIFO never overflows.
REQ-022 When count = 0, if_valid SHALL be 0; if_instr and if_pc are don't-care.
REQ-023 On redirect, in the same edge, SHALL:
- empty the FIFO;
- discard any inflight return;
- load fetch_pc = {redirect_pc[31:2], 2'b00}.
REQ-024 Redirect SHALL take priority over a simultaneous pop, push or issue.
REQ-025 After redirect in cycle R, SHALL issue at redirect_pc in R+1, and if_valid SHALL be 0 in R+1 and R+2.
REQ-026 While im_en = 0, im_add SHALL hold its last value.

Reset
REQ-027 While rst = 1, SHALL drive:
- im_en = 0, im_rd_wr = 0, if_valid = 0;
- count = 0, inflight = 0;
- fetch_pc = RESET_PC, im_add = RESET_PC.
REQ-028 rst SHALL override redirect and discard an inflight return; the first request occurs in the first cycle with rst = 0.

Configuration
REQ-029 With IF_PERF_CNT_EN defined, SHALL add two ports, both reset to 0 and wrapping at 2^32:
- fetch_cnt, output, 32 bits: +1 per FIFO push;
- flush_cnt, output, 32 bits: +1 per redirect cycle.
REQ-030 Without IF_PERF_CNT_EN, these ports and counters SHALL NOT exist, and all other behaviour is identical.

Verification
REQ-031 Reset release, id_ready = 1, memory returns word = address -> im_add = 0,4,8,... from cycle 0; if_valid from cycle 2; if_pc = if_instr = 0,4,8 consecutively.
REQ-032 id_ready = 0 for 10 cycles -> exactly 4 pushes, im_en low once count + inflight = 4, no loss; on id_ready = 1, pops in order 0,4,8,12, then fetch resumes at 16.
REQ-033 Redirect to 32'h0000_0103 with an inflight read of 0x20 -> 0x20 never appears; next im_add = 0x100; next if_pc = 0x100.
REQ-034 Redirect asserted together with a pop with count = 3 -> count = 0 next cycle; no stale entry is delivered.
REQ-035 Redirect to 32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst asserted mid-stream with a full FIFO -> if_valid = 0 the next cycle and restart at RESET_PC; with IF_PERF_CNT_EN, fetch_cnt = flush_cnt = 0.
